// File: rtl/mult_int2b_pkg.sv
// Shared types and elaboration helpers for the constant-coefficient multiplier.
// Consumed by csd_shift_add and top_mult_int2b.
package mult_int2b_pkg;

  localparam int unsigned DEF_BIT_WIDTH = 2;
  localparam int unsigned DEF_OUT_WIDTH = 2 * DEF_BIT_WIDTH;
  localparam int unsigned CSD_W         = 33;

  typedef logic signed [DEF_BIT_WIDTH-1:0] inp_t;
  typedef logic signed [DEF_OUT_WIDTH-1:0] prod_t;

  // Minimal signed-digit recoding of |coeff|; returns the +1 or the -1 digit mask.
  // The value 3 is kept as 2+1 rather than 4-1: same digit count, smaller shift.
  function automatic logic [CSD_W-1:0] csd_digits(input int coeff, input bit want_neg);
    longint            x;
    logic [CSD_W-1:0]  pos;
    logic [CSD_W-1:0]  neg;
    x   = (coeff < 0) ? -longint'(coeff) : longint'(coeff);
    pos = '0;
    neg = '0;
    for (int i = 0; i < int'(CSD_W); i++) begin
      if (x[0]) begin
        if (x[1] && (x != 64'sd3)) begin
          neg[i] = 1'b1;
          x      = x + 64'sd1;
        end else begin
          pos[i] = 1'b1;
          x      = x - 64'sd1;
        end
      end
      x = x >>> 1;
    end
    return want_neg ? neg : pos;
  endfunction

  // True when coeff * inp can never leave the signed ow-bit range.
  function automatic bit coeff_in_range(input int coeff, input int unsigned bw,
                                        input int unsigned ow);
    longint mag;
    longint lim;
    mag = ((coeff < 0) ? -longint'(coeff) : longint'(coeff)) <<< (bw - 1);
    lim = 64'sd1 <<< (ow - 1);
    return (coeff >= 0) ? (mag <= lim) : (mag <= lim - 64'sd1);
  endfunction

endpackage

// File: rtl/csd_shift_add.sv
// Combinational shift-add network for inp * COEFF, one term per nonzero CSD digit.
// With APPROX_MULT_EN defined, the lowest APPROX_BITS product bits are tied to zero.
module csd_shift_add
  import mult_int2b_pkg::*;
#(
  parameter int unsigned BIT_WIDTH   = DEF_BIT_WIDTH,
  parameter int unsigned OUT_WIDTH   = 2 * BIT_WIDTH,
  parameter int          COEFF       = 3,
  parameter int unsigned APPROX_BITS = 1
) (
  input  logic signed [BIT_WIDTH-1:0] inp,
  output logic signed [OUT_WIDTH-1:0] prod_c
);

  localparam logic [CSD_W-1:0] CSD_POS = csd_digits(COEFF, 1'b0);
  localparam logic [CSD_W-1:0] CSD_NEG = csd_digits(COEFF, 1'b1);

`ifdef APPROX_MULT_EN
  localparam logic [OUT_WIDTH-1:0] MASK = {OUT_WIDTH{1'b1}} << APPROX_BITS;
`else
  localparam logic [OUT_WIDTH-1:0] MASK = {OUT_WIDTH{1'b1}};
`endif

  generate
    if (APPROX_BITS >= OUT_WIDTH) begin : g_approx_err
      $error("APPROX_BITS must be smaller than OUT_WIDTH");
    end
  endgenerate

  logic signed [OUT_WIDTH-1:0] ext;
  logic signed [OUT_WIDTH-1:0] acc;

  // Terms shifted past the product width drop out modulo 2^OUT_WIDTH.
  always_comb begin
    ext = OUT_WIDTH'(inp);
    acc = '0;
    for (int i = 0; i < int'(CSD_W); i++) begin
      if (CSD_POS[i]) acc = acc + (ext <<< i);
      if (CSD_NEG[i]) acc = acc - (ext <<< i);
    end
    if (COEFF < 0) acc = -acc;
    prod_c = acc & MASK;
  end

endmodule

// File: rtl/top_mult_int2b.sv
// Registered signed constant-coefficient multiplier: out = inp * COEFF, one cycle latency.
// Optional macro APPROX_MULT_EN zeroes the low APPROX_BITS product bits.
module top_mult_int2b
  import mult_int2b_pkg::*;
#(
  parameter int unsigned BIT_WIDTH   = DEF_BIT_WIDTH,
  parameter int unsigned OUT_WIDTH   = 2 * BIT_WIDTH,
  parameter int          COEFF       = 3,
  parameter int unsigned APPROX_BITS = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [BIT_WIDTH-1:0] inp,
  output logic signed [OUT_WIDTH-1:0] out
);

  generate
    if (!coeff_in_range(COEFF, BIT_WIDTH, OUT_WIDTH)) begin : g_range_err
      $error("COEFF magnitude overflows the OUT_WIDTH product");
    end
  endgenerate

  logic signed [OUT_WIDTH-1:0] prod_c;

  csd_shift_add #(
    .BIT_WIDTH  (BIT_WIDTH),
    .OUT_WIDTH  (OUT_WIDTH),
    .COEFF      (COEFF),
    .APPROX_BITS(APPROX_BITS)
  ) u_csd (
    .inp   (inp),
    .prod_c(prod_c)
  );

  // Product register; reset clears it immediately, independent of clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) out <= '0;
    else     out <= prod_c;
  end

endmodule

// File: tb/tb_top_mult_int2b.sv
// Directed and streamed checks of top_mult_int2b at the default 2-bit, COEFF=3 configuration.
module tb_top_mult_int2b;
  import mult_int2b_pkg::*;

  logic  clk;
  logic  rst;
  inp_t  inp;
  prod_t out;

  int n_checks = 0;
  int n_fail   = 0;

  top_mult_int2b dut (
    .clk(clk),
    .rst(rst),
    .inp(inp),
    .out(out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  inp_t  vec_in     [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
  prod_t vec_exact  [4] = '{4'b0011, 4'b1101, 4'b1010, 4'b0000};
  prod_t vec_approx [4] = '{4'b0010, 4'b1100, 4'b1010, 4'b0000};

  task automatic check(input string tag, input prod_t got, input prod_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  function automatic prod_t hand_exp(input int idx);
`ifdef APPROX_MULT_EN
    return vec_approx[idx];
`else
    return vec_exact[idx];
`endif
  endfunction

  // Reference product from a plain integer multiply.
  function automatic prod_t model(input inp_t v);
    prod_t p;
    p = prod_t'(int'(v) * 3);
`ifdef APPROX_MULT_EN
    p = p & 4'b1110;
`endif
    return p;
  endfunction

  // Drive on the falling edge, sample 1 time unit after the next rising edge.
  task automatic apply(input inp_t v);
    @(negedge clk);
    inp = v;
    @(posedge clk);
    #1;
  endtask

  prod_t prev;

  initial begin
    rst = 1'b1;
    inp = 2'b01;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", out, 4'h0);

    @(negedge clk);
    check("reset_before_release", out, 4'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("first_capture_p1", out, hand_exp(0));

    apply(2'b11);
    check("neg1", out, hand_exp(1));
    apply(2'b10);
    check("neg2_extreme", out, hand_exp(2));
    apply(2'b00);
    check("zero", out, hand_exp(3));

    // Back-to-back stream; output must still show the old value before each edge.
    prev = hand_exp(3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      inp = vec_in[i];
      check("latency_hold", out, prev);
      @(posedge clk);
      #1;
      check("b2b", out, hand_exp(i));
      prev = hand_exp(i);
    end

    // Asynchronous reset in the middle of a cycle.
    apply(2'b10);
    check("pre_async_rst", out, hand_exp(2));
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_immediate", out, 4'h0);
    @(posedge clk);
    #1;
    check("async_rst_hold", out, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    inp = 2'b01;
    @(posedge clk);
    #1;
    check("resume_after_rst", out, hand_exp(0));

    // Random stream against the integer model.
    for (int i = 0; i < 2000; i++) begin
      inp_t v;
      v = inp_t'($urandom_range(0, 3));
      apply(v);
      check("stream", out, model(v));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
